load_store_unit: RTL

- Memory stage of the hart. Sits downstream of execute and upstream of register writeback.
- Accepts one LOAD/STORE request at a time and drives a word-wide, byte-enabled data-memory port with a valid/ready request and an rvalid response.
- Returns sign- or zero-extended load data, or a store acknowledge, to writeback.
- Width encoding is isa_types::write_width_t for both loads and stores.

---
 rtl/isa_types.sv | 20 ++
 rtl/lsu_lane_align.sv | 38 +++
 rtl/load_store_unit.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/isa_types.sv
// Shared ISA-level types for the hart: data width, access width encoding and LSU state.
package isa_types;

    localparam int XLEN     = 32;
    localparam int MEM_BE_W = XLEN / 8;

    typedef enum logic [1:0] {
        WW_BYTE = 2'd0,
        WW_HALF = 2'd1,
        WW_WORD = 2'd2
    } write_width_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } lsu_state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: store byte enables and replicated data, load extract and extend.
// Zero latency; no flow control of its own.
module lsu_lane_align
    import isa_types::*;
(
    input  write_width_t          i_width,
    input  logic [1:0]            i_off,
    input  logic                  i_unsigned,
    input  logic [XLEN-1:0]       i_wdata,
    input  logic [XLEN-1:0]       i_rdata,
    output logic [MEM_BE_W-1:0]   o_be,
    output logic [XLEN-1:0]       o_wdata,
    output logic [XLEN-1:0]       o_rdata
);

    logic [XLEN-1:0] w_sh;

    always_comb begin
        w_sh    = i_rdata >> {i_off, 3'b000};
        o_be    = {MEM_BE_W{1'b1}};
        o_wdata = i_wdata;
        o_rdata = w_sh;
        case (i_width)
            WW_BYTE: begin
                o_be    = MEM_BE_W'(1) << i_off;
                o_wdata = {MEM_BE_W{i_wdata[7:0]}};
                o_rdata = {{(XLEN-8){w_sh[7] & ~i_unsigned}}, w_sh[7:0]};
            end
            WW_HALF: begin
                o_be    = MEM_BE_W'(3) << i_off;
                o_wdata = {(MEM_BE_W/2){i_wdata[15:0]}};
                o_rdata = {{(XLEN-16){w_sh[15] & ~i_unsigned}}, w_sh[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: one LOAD/STORE at a time over a byte-enabled valid/ready + rvalid data port.
// Latency >= 3 cycles (1 with LSU_MISALIGN_TRAP_EN on a misaligned access); req_ready only in IDLE.
module load_store_unit
    import isa_types::*;
#(
    parameter int XLEN           = isa_types::XLEN,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_is_store,
    input  write_width_t        req_width,
    input  logic                req_unsigned,
    input  logic [XLEN-1:0]     req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    output logic                resp_valid,
    output logic [XLEN-1:0]     resp_rdata,
    output logic                resp_error,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [XLEN-1:0]     mem_addr,
    output logic                mem_we,
    output logic [MEM_BE_W-1:0] mem_be,
    output logic [XLEN-1:0]     mem_wdata,
    input  logic                mem_rvalid,
    input  logic [XLEN-1:0]     mem_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    lsu_state_t          r_state;
    logic                r_is_store;
    logic                r_unsigned;
    write_width_t        r_width;
    logic [1:0]          r_off;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_mem_req_valid;
    logic                r_mem_we;
    logic [MEM_BE_W-1:0] r_mem_be;
    logic [XLEN-1:0]     r_mem_addr;
    logic [XLEN-1:0]     r_mem_wdata;
    logic                r_resp_valid;
    logic                r_resp_error;
    logic [XLEN-1:0]     r_resp_rdata;

    logic                w_hs;
    logic                w_trap;
    logic                w_timeout;
    logic [1:0]          w_off;
    logic [1:0]          w_al_off;
    write_width_t        w_al_width;
    logic [MEM_BE_W-1:0] w_be;
    logic [XLEN-1:0]     w_wdata;
    logic [XLEN-1:0]     w_rdata;

    assign req_ready = (r_state == IDLE) && !reset;
    assign w_hs      = req_valid && req_ready;

    // Offset bits below the access size are dropped, so a non-trapping misaligned access goes aligned.
    always_comb begin
        w_off = req_addr[1:0];
        case (req_width)
            WW_BYTE: w_off = req_addr[1:0];
            WW_HALF: w_off = {req_addr[1], 1'b0};
            default: w_off = 2'b00;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_trap = ((req_width == WW_HALF) && req_addr[0]) ||
                    ((req_width != WW_BYTE) && (req_width != WW_HALF) && (req_addr[1:0] != 2'b00));
`else
    assign w_trap = 1'b0;
`endif

    // Counter reads k-1 in the k-th cycle after the handshake, so the error response lands at TIMEOUT_CYCLES.
    assign w_timeout  = r_cnt >= CNT_W'(TIMEOUT_CYCLES - 2);
    assign w_al_width = (r_state == IDLE) ? req_width : r_width;
    assign w_al_off   = (r_state == IDLE) ? w_off : r_off;

    lsu_lane_align u_align (
        .i_width    (w_al_width),
        .i_off      (w_al_off),
        .i_unsigned (r_unsigned),
        .i_wdata    (req_wdata),
        .i_rdata    (mem_rdata),
        .o_be       (w_be),
        .o_wdata    (w_wdata),
        .o_rdata    (w_rdata)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state         <= IDLE;
            r_is_store      <= 1'b0;
            r_unsigned      <= 1'b0;
            r_width         <= WW_BYTE;
            r_off           <= 2'b00;
            r_cnt           <= '0;
            r_mem_req_valid <= 1'b0;
            r_mem_we        <= 1'b0;
            r_mem_be        <= '0;
            r_mem_addr      <= '0;
            r_mem_wdata     <= '0;
            r_resp_valid    <= 1'b0;
            r_resp_error    <= 1'b0;
            r_resp_rdata    <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_error <= 1'b0;
            r_resp_rdata <= '0;
            case (r_state)
                IDLE: begin
                    if (w_hs) begin
                        r_is_store <= req_is_store;
                        r_unsigned <= req_unsigned;
                        r_width    <= req_width;
                        r_off      <= w_off;
                        r_cnt      <= '0;
                        if (w_trap) begin
                            r_state      <= RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_error <= 1'b1;
                        end else begin
                            r_state         <= ISSUE;
                            r_mem_req_valid <= 1'b1;
                            r_mem_we        <= req_is_store;
                            r_mem_be        <= w_be;
                            r_mem_addr      <= {req_addr[XLEN-1:2], 2'b00};
                            r_mem_wdata     <= w_wdata;
                        end
                    end
                end
                ISSUE: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_timeout) begin
                        r_state         <= RESP;
                        r_mem_req_valid <= 1'b0;
                        r_resp_valid    <= 1'b1;
                        r_resp_error    <= 1'b1;
                    end else if (mem_req_ready) begin
                        r_state         <= WAIT;
                        r_mem_req_valid <= 1'b0;
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (mem_rvalid) begin
                        r_state      <= RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= r_is_store ? '0 : w_rdata;
                    end else if (w_timeout) begin
                        r_state      <= RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_error <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign resp_valid    = r_resp_valid;
    assign resp_error    = r_resp_error;
    assign resp_rdata    = r_resp_rdata;
    assign mem_req_valid = r_mem_req_valid;
    assign mem_we        = r_mem_we;
    assign mem_be        = r_mem_be;
    assign mem_addr      = r_mem_addr;
    assign mem_wdata     = r_mem_wdata;

endmodule
